// File: rtl/tape_pkg.sv
// Shared mode codes and FSM state encoding for the tape loader.
package tape_pkg;

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_CLEAR = 2'b01;
    localparam logic [1:0] MODE_DUMP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        DUMP,
        DONE
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: a held level produces exactly one single-cycle pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= in;
    end

    assign out = in & ~prev_q;

endmodule

// File: rtl/tape_loader.sv
// Front-panel controller that loads, clears or reads back the Turing-machine tape RAM.
// Every output comes straight from a register; the comb block only computes next state.
module tape_loader
    import tape_pkg::*;
#(
    parameter int                 DATA_W = 8,
    parameter int                 ADDR_W = 7,
    parameter int                 DEPTH  = 128,
    parameter logic [DATA_W-1:0]  BLANK  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dugme,
    input  logic              posalji,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] adresa,
    output logic              wren,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] adresa_q, adresa_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wren_q, wren_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              step;

    rise_detect u_step (
        .clk   (clk),
        .reset (reset),
        .in    (posalji),
        .out   (step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            adresa_q   <= '0;
            dout_q     <= '0;
            rd_data_q  <= '0;
            wren_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adresa_q   <= adresa_d;
            dout_q     <= dout_d;
            rd_data_q  <= rd_data_d;
            wren_q     <= wren_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path can infer a latch.
        state_d    = state_q;
        adresa_d   = adresa_q;
        dout_d     = dout_q;
        rd_data_d  = rd_data_q;
        wren_d     = 1'b0;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;

        unique case (state_q)
            IDLE: begin
                adresa_d = '0;
                busy_d   = 1'b0;
                done_d   = 1'b0;
                if (dugme) begin
                    case (mode)
                        MODE_LOAD:  begin state_d = LOAD; busy_d = 1'b1; end
                        MODE_CLEAR: begin
                            state_d = CLEAR;
                            busy_d  = 1'b1;
                            wren_d  = 1'b1;
                            dout_d  = BLANK;
                        end
                        MODE_DUMP:  begin state_d = DUMP; busy_d = 1'b1; end
                        default:    ;
                    endcase
                end
            end

            // A write occupies one cycle; the address advances on the cycle after it.
            LOAD: begin
                if (!dugme) begin
                    state_d = IDLE; adresa_d = '0; busy_d = 1'b0; done_d = 1'b0;
                end else if (wren_q) begin
                    if (adresa_q == LAST) begin
                        state_d = DONE; busy_d = 1'b0; done_d = 1'b1;
                    end else begin
                        adresa_d = adresa_q + ADDR_W'(1);
                    end
                end else if (step) begin
                    wren_d = 1'b1;
                    dout_d = din;
                end
            end

            CLEAR: begin
                if (!dugme) begin
                    state_d = IDLE; adresa_d = '0; busy_d = 1'b0; done_d = 1'b0;
                end else if (adresa_q == LAST) begin
                    state_d = DONE; busy_d = 1'b0; done_d = 1'b1;
                end else begin
                    adresa_d = adresa_q + ADDR_W'(1);
                    wren_d   = 1'b1;
                    dout_d   = BLANK;
                end
            end

            DUMP: begin
                if (!dugme) begin
                    state_d = IDLE; adresa_d = '0; busy_d = 1'b0; done_d = 1'b0;
                end else if (step) begin
                    rd_data_d  = mem_q;
                    rd_valid_d = 1'b1;
                    if (adresa_q == LAST) begin
                        state_d = DONE; busy_d = 1'b0; done_d = 1'b1;
                    end else begin
                        adresa_d = adresa_q + ADDR_W'(1);
                    end
                end
            end

            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (!dugme) begin
                    state_d = IDLE; adresa_d = '0; done_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE; adresa_d = '0; busy_d = 1'b0; done_d = 1'b0;
            end
        endcase
    end

    assign dout     = dout_q;
    assign adresa   = adresa_q;
    assign wren     = wren_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tape_loader.sv
// Bench for tape_loader: a 4-cell instance with a RAM model and a 128-cell instance for clear.
module tb_tape_loader;
    import tape_pkg::*;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    logic       s_dugme, s_posalji, s_wren, s_rd_valid, s_busy, s_done;
    logic [1:0] s_mode;
    logic [7:0] s_din, s_mem_q, s_dout, s_rd_data;
    logic [6:0] s_adresa;

    logic       b_dugme, b_posalji, b_wren, b_rd_valid, b_busy, b_done;
    logic [1:0] b_mode;
    logic [7:0] b_din, b_mem_q, b_dout, b_rd_data;
    logic [6:0] b_adresa;

    logic [7:0] mem [4];

    int   checks = 0;
    int   errors = 0;
    int   w_cnt  = 0;
    int   r_cnt  = 0;
    wr_t        wr_q [$];
    logic [7:0] rd_q [$];
    wr_t        mon_wr;
    logic [7:0] mon_rd;

    always #5 clk = ~clk;

    tape_loader #(.DATA_W(8), .ADDR_W(7), .DEPTH(4), .BLANK(8'h00)) u_small (
        .clk(clk), .reset(reset), .dugme(s_dugme), .posalji(s_posalji), .mode(s_mode),
        .din(s_din), .mem_q(s_mem_q), .dout(s_dout), .adresa(s_adresa), .wren(s_wren),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .busy(s_busy), .done(s_done)
    );

    tape_loader #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .BLANK(8'h00)) u_big (
        .clk(clk), .reset(reset), .dugme(b_dugme), .posalji(b_posalji), .mode(b_mode),
        .din(b_din), .mem_q(b_mem_q), .dout(b_dout), .adresa(b_adresa), .wren(b_wren),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy), .done(b_done)
    );

    // Single-port RAM with registered read, read-before-write.
    always @(posedge clk) begin
        if (s_wren) mem[s_adresa[1:0]] <= s_dout;
        s_mem_q <= mem[s_adresa[1:0]];
    end

    // Scoreboard: every write/readback pulse of the small instance must match a queued entry.
    always @(negedge clk) begin
        if (reset && s_wren) begin
            checks++;
            w_cnt++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h, none expected", s_adresa, s_dout);
            end else begin
                mon_wr = wr_q.pop_front();
                if (s_adresa !== mon_wr.addr || s_dout !== mon_wr.data) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             s_adresa, s_dout, mon_wr.addr, mon_wr.data);
                end
            end
        end
        if (reset && s_rd_valid) begin
            checks++;
            r_cnt++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got rd_data=%h, none expected", s_rd_data);
            end else begin
                mon_rd = rd_q.pop_front();
                if (s_rd_data !== mon_rd) begin
                    errors++;
                    $display("FAIL readback got %h want %h", s_rd_data, mon_rd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({s_adresa, s_dout, s_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_small_data got adresa=%0d dout=%h rd_data=%h want 0", s_adresa, s_dout, s_rd_data);
        end
        checks++;
        if ({s_wren, s_rd_valid, s_busy, s_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_small_flags got %b want 0000", {s_wren, s_rd_valid, s_busy, s_done});
        end
        checks++;
        if ({b_adresa, b_wren, b_busy, b_done} !== '0) begin
            errors++;
            $display("FAIL reset_big got adresa=%0d wren=%b busy=%b done=%b want 0", b_adresa, b_wren, b_busy, b_done);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_adresa !== 7'd0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b adresa=%0d want 0 0", s_busy, s_adresa);
        end
    endtask

    task automatic press_small(input int hold);
        s_posalji = 1'b1;
        tick();
        repeat (hold - 1) tick();
        s_posalji = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int w0;
        s_mode  = MODE_LOAD;
        s_dugme = 1'b1;
        tick();
        checks++;
        if (s_busy !== 1'b1 || s_adresa !== 7'd0) begin
            errors++;
            $display("FAIL load_start got busy=%b adresa=%0d want 1 0", s_busy, s_adresa);
        end
        w0 = w_cnt;
        for (int i = 0; i < 4; i++) begin
            s_din = 8'(8'hA1 + i);
            wr_q.push_back('{addr: 7'(i), data: s_din});
            press_small((i == 0) ? 10 : 1);
            checks++;
            if (s_wren !== 1'b0) begin
                errors++;
                $display("FAIL load_wren_low idx=%0d got %b want 0", i, s_wren);
            end
        end
        checks++;
        if (w_cnt - w0 !== 4 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL load_count got %0d writes want 4", w_cnt - w0);
        end
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_adresa !== 7'd3) begin
            errors++;
            $display("FAIL load_done got done=%b busy=%b adresa=%0d want 1 0 3", s_done, s_busy, s_adresa);
        end
    endtask

    task automatic test_done_hold();
        int w0;
        w0 = w_cnt;
        repeat (20) tick();
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_adresa !== 7'd3 || w_cnt != w0) begin
            errors++;
            $display("FAIL done_hold got done=%b busy=%b adresa=%0d writes=%0d want 1 0 3 0",
                     s_done, s_busy, s_adresa, w_cnt - w0);
        end
        s_dugme = 1'b0;
        tick();
        checks++;
        if (s_done !== 1'b0 || s_adresa !== 7'd0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_release got done=%b adresa=%0d busy=%b want 0 0 0", s_done, s_adresa, s_busy);
        end
    endtask

    task automatic test_dump();
        int w0;
        int r0;
        w0 = w_cnt;
        r0 = r_cnt;
        s_mode  = MODE_DUMP;
        s_dugme = 1'b1;
        tick();
        checks++;
        if (s_busy !== 1'b1 || s_adresa !== 7'd0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL dump_start got busy=%b adresa=%0d done=%b want 1 0 0", s_busy, s_adresa, s_done);
        end
        for (int i = 0; i < 4; i++) begin
            rd_q.push_back(8'(8'hA1 + i));
            press_small(1);
        end
        checks++;
        if (r_cnt - r0 != 4 || rd_q.size() != 0 || w_cnt != w0) begin
            errors++;
            $display("FAIL dump_count got reads=%0d writes=%0d want 4 0", r_cnt - r0, w_cnt - w0);
        end
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL dump_done got done=%b busy=%b want 1 0", s_done, s_busy);
        end
        s_dugme = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int w0;
        w0 = w_cnt;
        s_mode  = MODE_LOAD;
        s_dugme = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            s_din = 8'(8'hB1 + i);
            wr_q.push_back('{addr: 7'(i), data: s_din});
            press_small(1);
        end
        s_din     = 8'hB3;
        s_posalji = 1'b1;
        s_dugme   = 1'b0;
        tick();
        checks++;
        if (s_wren !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_adresa !== 7'd0) begin
            errors++;
            $display("FAIL abort got wren=%b busy=%b done=%b adresa=%0d want 0 0 0 0",
                     s_wren, s_busy, s_done, s_adresa);
        end
        s_posalji = 1'b0;
        tick();
        tick();
        checks++;
        if (w_cnt - w0 != 2 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL abort_count got %0d writes want 2", w_cnt - w0);
        end
        checks++;
        if (mem[0] !== 8'hB1 || mem[1] !== 8'hB2 || mem[2] !== 8'hA3 || mem[3] !== 8'hA4) begin
            errors++;
            $display("FAIL abort_ram got %h %h %h %h want b1 b2 a3 a4", mem[0], mem[1], mem[2], mem[3]);
        end
    endtask

    task automatic test_clear();
        int n = 0;
        int bad_addr = 0;
        int gap = 0;
        bit ended = 0;
        b_mode  = MODE_CLEAR;
        b_dugme = 1'b1;
        for (int t = 0; t < 200 && b_done !== 1'b1; t++) begin
            tick();
            if (b_wren === 1'b1) begin
                if (b_adresa !== 7'(n) || b_dout !== 8'h00) bad_addr++;
                if (ended) gap++;
                n++;
            end else if (n > 0) begin
                ended = 1;
            end
        end
        checks++;
        if (n != 128 || gap != 0) begin
            errors++;
            $display("FAIL clear_len got %0d write cycles gaps=%0d want 128 0", n, gap);
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL clear_addr got %0d bad address/data cycles want 0", bad_addr);
        end
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_adresa !== 7'd127) begin
            errors++;
            $display("FAIL clear_done got done=%b busy=%b adresa=%0d want 1 0 127", b_done, b_busy, b_adresa);
        end
        b_dugme = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        b_mode  = MODE_CLEAR;
        b_dugme = 1'b1;
        for (int t = 0; t < 100 && b_adresa !== 7'd37; t++) tick();
        checks++;
        if (b_adresa !== 7'd37 || b_wren !== 1'b1) begin
            errors++;
            $display("FAIL midclear_reach got adresa=%0d wren=%b want 37 1", b_adresa, b_wren);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (b_wren !== 1'b0 || b_adresa !== 7'd0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_reset got wren=%b adresa=%0d busy=%b want 0 0 0", b_wren, b_adresa, b_busy);
        end
        b_mode = 2'b11;
        reset  = 1'b1;
        repeat (5) tick();
        checks++;
        if (b_busy !== 1'b0 || b_wren !== 1'b0 || b_adresa !== 7'd0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL reserved_mode got busy=%b wren=%b adresa=%0d done=%b want 0 0 0 0",
                     b_busy, b_wren, b_adresa, b_done);
        end
        b_dugme = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        s_dugme   = 1'b0; s_posalji = 1'b0; s_mode = MODE_LOAD; s_din = 8'h00;
        b_dugme   = 1'b0; b_posalji = 1'b0; b_mode = MODE_LOAD; b_din = 8'h00;
        b_mem_q   = 8'h00;
        for (int i = 0; i < 4; i++) mem[i] = 8'hEE;
        test_reset();
        test_load();
        test_done_hold();
        test_dump();
        test_abort();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
